// File: rtl/neopix_pkg.sv
// Shared types and constants for the NeoPixel double-buffered frame controller.
// Pure declarations: no logic, no latency, no handshake.
package neopix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_LATCH
    } rd_state_e;

    localparam int unsigned BANK_WORDS       = 256;
    localparam int unsigned RAM_AW           = 9;
    localparam int unsigned LATCH_CYCLES_DEF = 15000;
    localparam int unsigned QUEUE_DEPTH      = 3;

endpackage

// File: rtl/neopix_out_queue.sv
// Three-entry register FIFO holding RAM read data on its way to the serializer.
// Latency: push visible at head the next cycle; pop of an empty queue and push into a full one (without pop) are ignored.
module neopix_out_queue
    import neopix_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic [31:0] data_i,
    input  logic        pop_i,
    output logic [1:0]  count_o,
    output logic [31:0] head_o,
    output logic        empty_o
);

    logic [31:0] mem_q [QUEUE_DEPTH];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        do_push, do_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(QUEUE_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign do_pop  = pop_i & (cnt_q != 2'd0);
    assign do_push = push_i & ((cnt_q != 2'(QUEUE_DEPTH)) | do_pop);

    always_comb begin
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/neopix_frame_ctrl.sv
// Double-buffered pixel frame controller: host fills the back bank, reader streams the front bank to the serializer.
// Latency: write 0 cycles, read address to px_valid 3 cycles; host stalls while a commit is pending, reads stop at 3 credits.
module neopix_frame_ctrl
    import neopix_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES = LATCH_CYCLES_DEF,
    parameter int unsigned QDEPTH       = QUEUE_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_valid_i,
    input  logic [31:0]       wr_data_i,
    input  logic              wr_last_i,
    output logic              wr_ready_o,
    output logic              overflow_o,
    output logic              px_valid_o,
    output logic [31:0]       px_data_o,
    input  logic              px_ready_i,
    output logic              frame_done_o,
    output logic [RAM_AW-1:0] ram_wraddr_o,
    output logic [31:0]       ram_data_o,
    output logic              ram_wren_o,
    output logic [RAM_AW-1:0] ram_rdaddr_o,
    input  logic [31:0]       ram_q_i
);

    localparam int unsigned LW = $clog2(LATCH_CYCLES + 1);

    rd_state_e     state_q;
    logic          disp_bank_q, pend_q, overflow_q, frame_done_q;
    logic [8:0]    wr_cnt_q, wr_cnt_d, pend_len_q, len_q, rd_cnt_q;
    logic [1:0]    infl_q;
    logic [LW-1:0] latch_cnt_q;

    logic          wr_fire, wr_room, wr_commit;
    logic          issue, q_pop, q_empty;
    logic [1:0]    q_cnt;
    logic [31:0]   q_head;
    logic [2:0]    credit;

    // Host side: the writer only ever touches the back bank, never the one being streamed.
    assign wr_ready_o   = ~pend_q;
    assign wr_fire      = wr_valid_i & ~pend_q;
    assign wr_room      = ~wr_cnt_q[8];
    assign wr_commit    = wr_fire & wr_last_i;
    assign ram_wren_o   = wr_fire & wr_room;
    assign ram_wraddr_o = ram_wren_o ? {~disp_bank_q, wr_cnt_q[7:0]} : '0;
    assign ram_data_o   = ram_wren_o ? wr_data_i : '0;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (wr_commit) begin
            wr_cnt_d = '0;
        end else if (ram_wren_o) begin
            wr_cnt_d = wr_cnt_q + 9'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
            pend_len_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            if (wr_fire && !wr_room) begin
                overflow_q <= 1'b1;
            end
            if (wr_commit) begin
                pend_len_q <= wr_room ? wr_cnt_q + 9'd1 : 9'(BANK_WORDS);
            end
        end
    end

    // Credit covers reads still in the RAM pipeline plus words parked in the queue.
    assign credit       = {1'b0, q_cnt} + {2'b00, infl_q[0]} + {2'b00, infl_q[1]};
    assign issue        = (state_q == ST_STREAM) && (credit < 3'(QDEPTH));
    assign ram_rdaddr_o = issue ? {disp_bank_q, rd_cnt_q[7:0]} : '0;
    assign q_pop        = ~q_empty & px_ready_i;

    neopix_out_queue u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (infl_q[1]),
        .data_i  (ram_q_i),
        .pop_i   (q_pop),
        .count_o (q_cnt),
        .head_o  (q_head),
        .empty_o (q_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            disp_bank_q  <= 1'b0;
            pend_q       <= 1'b0;
            len_q        <= '0;
            rd_cnt_q     <= '0;
            infl_q       <= '0;
            latch_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            infl_q       <= {infl_q[0], issue};
            frame_done_q <= 1'b0;
            if (wr_commit) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        disp_bank_q <= ~disp_bank_q;
                        len_q       <= pend_len_q;
                        rd_cnt_q    <= '0;
                        pend_q      <= 1'b0;
                        state_q     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (issue) begin
                        rd_cnt_q <= rd_cnt_q + 9'd1;
                        if (rd_cnt_q + 9'd1 == len_q) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave as the final word is taken so the gap counts from the last accept.
                    if (infl_q == 2'b00 && (q_empty || (q_cnt == 2'd1 && q_pop))) begin
                        latch_cnt_q  <= LW'(LATCH_CYCLES - 1);
                        frame_done_q <= (LATCH_CYCLES == 1);
                        state_q      <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (latch_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        latch_cnt_q <= latch_cnt_q - LW'(1);
                    end
                    if (latch_cnt_q == LW'(1)) begin
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign overflow_o   = overflow_q;
    assign frame_done_o = frame_done_q;
    assign px_valid_o   = ~q_empty;
    assign px_data_o    = q_head;

endmodule

// File: tb/tb_neopix_frame_ctrl.sv
// Scoreboard bench for neopix_frame_ctrl with a behavioural RAM and a frame-level reference model.
module tb_neopix_frame_ctrl;

    localparam int LC = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid_i, wr_last_i, wr_ready_o, overflow_o;
    logic [31:0] wr_data_i;
    logic        px_valid_o, px_ready_i, frame_done_o, ram_wren_o;
    logic [31:0] px_data_o, ram_data_o, ram_q_i;
    logic [8:0]  ram_wraddr_o, ram_rdaddr_o, rd_addr_q, exp_wa;
    logic [31:0] mem [512];

    logic [31:0] exp_q[$];
    logic [31:0] cur_frame[$];
    logic [31:0] pxd;
    logic [86:0] rst_vec;
    int checks = 0, errors = 0;
    int cyc = 0, wr_idx = 0, frame_k = 0, nwrites = 0, pop_cnt = 0, iss_cnt = 0, done_cnt = 0;
    int last_pop_cyc = 0, first_vld_cyc = -1, commit_cyc = 0, rdy_mode = 0;
    bit chk_credit = 0, watch_vld = 0;

    neopix_frame_ctrl #(.LATCH_CYCLES(LC)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_valid_i   (wr_valid_i),
        .wr_data_i    (wr_data_i),
        .wr_last_i    (wr_last_i),
        .wr_ready_o   (wr_ready_o),
        .overflow_o   (overflow_o),
        .px_valid_o   (px_valid_o),
        .px_data_o    (px_data_o),
        .px_ready_i   (px_ready_i),
        .frame_done_o (frame_done_o),
        .ram_wraddr_o (ram_wraddr_o),
        .ram_data_o   (ram_data_o),
        .ram_wren_o   (ram_wren_o),
        .ram_rdaddr_o (ram_rdaddr_o),
        .ram_q_i      (ram_q_i)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port RAM with registered address and registered output.
    always @(posedge clk) begin
        if (ram_wren_o) mem[ram_wraddr_o] <= ram_data_o;
        rd_addr_q <= ram_rdaddr_o;
        ram_q_i   <= mem[rd_addr_q];
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        px_ready_i = 1'b1;
        forever begin
            tick();
            case (rdy_mode)
                0:       px_ready_i = 1'b1;
                1:       px_ready_i = 1'($urandom_range(0, 1));
                default: px_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: write-port model, read-credit observation, pixel scoreboard, latch gap.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wren_o) nwrites++;
            if (wr_valid_i && wr_ready_o) begin
                if (wr_idx < 256) begin
                    exp_wa = {~frame_k[0], wr_idx[7:0]};
                    chk("wr_port", {ram_wren_o, ram_wraddr_o, ram_data_o}, {1'b1, exp_wa, wr_data_i});
                    cur_frame.push_back(wr_data_i);
                end else begin
                    chk("wr_drop", ram_wren_o, 1'b0);
                end
                wr_idx++;
                if (wr_last_i) begin
                    foreach (cur_frame[i]) exp_q.push_back(cur_frame[i]);
                    cur_frame.delete();
                    wr_idx = 0;
                    frame_k++;
                end
            end else begin
                chk("wr_idle", ram_wren_o, 1'b0);
            end
            if (chk_credit) begin
                if (ram_rdaddr_o != 9'd0) begin
                    chk("rd_addr", ram_rdaddr_o, {1'b1, iss_cnt[7:0]});
                    iss_cnt++;
                end
                chk("credit_le3", (iss_cnt - pop_cnt) <= 3, 1'b1);
            end
            if (watch_vld && px_valid_o) begin
                first_vld_cyc = cyc;
                watch_vld = 0;
            end
            if (px_valid_o && px_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("px_unexpected", px_data_o, 32'hdead_beef);
                end else begin
                    pxd = exp_q.pop_front();
                    chk("px_data", px_data_o, pxd);
                end
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            if (frame_done_o) begin
                done_cnt++;
                chk("latch_gap", cyc - last_pop_cyc, LC);
            end
        end
    end

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        wr_valid_i = 1'b0;
        wr_last_i = 1'b0;
        exp_q.delete();
        cur_frame.delete();
        wr_idx = 0; frame_k = 0; nwrites = 0; pop_cnt = 0; iss_cnt = 0; done_cnt = 0;
        watch_vld = 0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string nm);
        rst_vec = {wr_ready_o, overflow_o, px_valid_o, px_data_o, frame_done_o,
                   ram_wraddr_o, ram_data_o, ram_wren_o, ram_rdaddr_o};
        chk(nm, rst_vec, {1'b1, 86'd0});
    endtask

    task automatic put(input logic [31:0] d, input logic last);
        int guard = 0;
        wr_valid_i = 1'b1;
        wr_data_i  = d;
        wr_last_i  = last;
        while (!wr_ready_o && guard < 3000) begin
            tick();
            guard++;
        end
        if (!wr_ready_o) chk("wr_ready_timeout", wr_ready_o, 1'b1);
        tick();
        wr_valid_i = 1'b0;
        wr_last_i  = 1'b0;
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) put($urandom, i == n - 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("frame_done_seen", done_cnt >= target, 1'b1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; wr_valid_i = 1'b0; wr_last_i = 1'b0; wr_data_i = '0;
        tick();

        // Single frame
        do_reset(2);
        check_reset_outputs("reset_outputs");
        rdy_mode = 0;
        put(32'h11, 1'b0); put(32'h22, 1'b0); put(32'h33, 1'b0); put(32'h44, 1'b1);
        wait_done(1, 200);
        chk("t1_ram_writes", nwrites, 4);
        chk("t1_all_streamed", exp_q.size(), 0);
        repeat (30) tick();
        chk("t1_single_pulse", done_cnt, 1);

        // Backpressure
        do_reset(2);
        chk_credit = 1;
        rdy_mode = 2;
        send_rand(10);
        repeat (15) tick();
        rdy_mode = 1;
        wait_done(1, 500);
        chk_credit = 0;
        rdy_mode = 0;
        chk("t2_pops", pop_cnt, 10);
        chk("t2_issues", iss_cnt, 10);
        chk("t2_all_streamed", exp_q.size(), 0);

        // Pending commit while streaming
        do_reset(2);
        rdy_mode = 1;
        send_rand(12);
        repeat (3) tick();
        send_rand(5);
        n = 0;
        while (!frame_done_o && n < 1000) begin
            chk("t3_hold_ready", wr_ready_o, 1'b0);
            tick();
            n++;
        end
        chk("t3_a_done", frame_done_o, 1'b1);
        chk("t3_ready_at_done", wr_ready_o, 1'b0);
        tick();
        chk("t3_ready_swap", wr_ready_o, 1'b0);
        tick();
        chk("t3_ready_rise", wr_ready_o, 1'b1);
        wait_done(2, 500);
        rdy_mode = 0;
        chk("t3_all_streamed", exp_q.size(), 0);

        // Overflow
        do_reset(2);
        send_rand(300);
        chk("t4_overflow", overflow_o, 1'b1);
        chk("t4_ram_writes", nwrites, 256);
        wait_done(1, 2000);
        chk("t4_pops", pop_cnt, 256);
        chk("t4_all_streamed", exp_q.size(), 0);

        // Reset mid-stream
        do_reset(2);
        rdy_mode = 2;
        send_rand(6);
        repeat (8) tick();
        do_reset(1);
        check_reset_outputs("t5_reset_outputs");
        rdy_mode = 0;
        send_rand(2);
        wait_done(1, 200);
        chk("t5_pops", pop_cnt, 2);
        chk("t5_all_streamed", exp_q.size(), 0);

        // Commit on the LATCH -> IDLE edge
        do_reset(2);
        send_rand(3);
        put($urandom, 1'b0);
        put($urandom, 1'b0);
        n = 0;
        while (!frame_done_o && n < 500) begin
            tick();
            n++;
        end
        chk("t6_done_seen", frame_done_o, 1'b1);
        wr_valid_i = 1'b1; wr_data_i = $urandom; wr_last_i = 1'b1;
        commit_cyc = cyc;
        first_vld_cyc = -1;
        watch_vld = 1;
        chk("t6_ready_at_commit", wr_ready_o, 1'b1);
        tick();
        wr_valid_i = 1'b0; wr_last_i = 1'b0;
        chk("t6_pend_visible", wr_ready_o, 1'b0);
        tick();
        chk("t6_ready_after_swap", wr_ready_o, 1'b1);
        n = 0;
        while (watch_vld && n < 50) begin
            tick();
            n++;
        end
        chk("t6_first_valid", first_vld_cyc - commit_cyc, 5);
        wait_done(2, 300);
        chk("t6_all_streamed", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
